// File: rtl/kypd_matrix_scanner.sv
// Column-scanning keypad controller: per-key debounce, debounced key map and a
// first-word-fall-through press/release event FIFO.
module kypd_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DWELL_CYCLES   = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8,
  localparam int KEYS          = ROWS * COLS,
  localparam int KW            = $clog2(KEYS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [COLS-1:0] col_n_o,
  input  logic [ROWS-1:0] row_n_i,
  output logic [KEYS-1:0] keys_o,
  output logic            ev_valid_o,
  input  logic            ev_ready_i,
  output logic [KW-1:0]   ev_key_o,
  output logic            ev_press_o,
  output logic            overflow_o,
  input  logic            ovf_clr_i
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_DRIVE, S_SAMPLE, S_UPDATE, S_NEXT} state_e;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [CW-1:0]   col_d;
  logic [RW-1:0]   row_q;
  logic [DW-1:0]   dwell_q;
  logic [COLS-1:0] col_n_q;
  logic [ROWS-1:0] sync1_q, sync2_q, samp_q;
  logic [KEYS-1:0] keys_q;
  logic [3:0]      cnt_q [KEYS];
  logic [3:0]      cnt_d;
  logic [KW-1:0]   key_idx;
  logic            push_q;
  logic [KW-1:0]   push_key_q;
  logic            push_press_q;

  logic [KW:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     fcnt_q;
  logic            overflow_q;
  logic            full, pop, wr_en;

  always_ff @(posedge clk_i) begin
    sync1_q <= row_n_i;
    sync2_q <= sync1_q;
  end

  always_comb begin
    key_idx = KW'(int'(row_q) * COLS + int'(col_q));
    cnt_d   = cnt_q[key_idx] + 4'd1;
    col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
  end

  // Scan FSM and debounce; the event request is registered on the same edge as keys.
  always_ff @(posedge clk_i) begin
    push_q <= 1'b0;
    if (rst_i) begin
      state_q <= S_DRIVE;
      col_q   <= '0;
      row_q   <= '0;
      dwell_q <= '0;
      col_n_q <= '1;
      keys_q  <= '0;
      for (int k = 0; k < KEYS; k++) cnt_q[k] <= '0;
    end else begin
      case (state_q)
        S_DRIVE: begin
          col_n_q <= ~(COLS'(1) << col_q);
          if (dwell_q == DW'(DWELL_CYCLES - 1)) state_q <= S_SAMPLE;
          else dwell_q <= dwell_q + DW'(1);
        end
        S_SAMPLE: begin
          samp_q  <= ~sync2_q;
          row_q   <= '0;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          if (samp_q[row_q] == keys_q[key_idx]) begin
            cnt_q[key_idx] <= '0;
          end else if (cnt_d == 4'(DEBOUNCE_SCANS)) begin
            keys_q[key_idx] <= samp_q[row_q];
            cnt_q[key_idx]  <= '0;
            push_q          <= 1'b1;
            push_key_q      <= key_idx;
            push_press_q    <= samp_q[row_q];
          end else begin
            cnt_q[key_idx] <= cnt_d;
          end
          if (row_q == RW'(ROWS - 1)) state_q <= S_NEXT;
          else row_q <= row_q + RW'(1);
        end
        default: begin
          col_q   <= col_d;
          col_n_q <= ~(COLS'(1) << col_d);
          dwell_q <= '0;
          state_q <= S_DRIVE;
        end
      endcase
    end
  end

  assign full  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = ev_valid_o & ev_ready_i;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= {push_key_q, push_press_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   fcnt_q <= fcnt_q + (AW+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (AW+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (push_q & full & ~pop) overflow_q <= 1'b1;
      else if (ovf_clr_i)       overflow_q <= 1'b0;
    end
  end

  assign col_n_o    = col_n_q;
  assign keys_o     = keys_q;
  assign ev_valid_o = (fcnt_q != '0);
  assign ev_key_o   = mem_q[rd_q][KW:1];
  assign ev_press_o = mem_q[rd_q][0];
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_kypd_matrix_scanner.sv
// Directed bench for kypd_matrix_scanner on a 4x4 keypad model with short dwell.
module tb_kypd_matrix_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN = COLS * (16 + ROWS + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keys;
  logic        ev_valid;
  logic        ev_ready = 1'b1;
  logic [3:0]  ev_key;
  logic        ev_press;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [15:0] pressed = '0;

  logic [4:0]  evq [$];
  int          n_chk = 0;
  int          n_pass = 0;

  kypd_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(16), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .col_n_o(col_n), .row_n_i(row_n), .keys_o(keys),
    .ev_valid_o(ev_valid), .ev_ready_i(ev_ready), .ev_key_o(ev_key),
    .ev_press_o(ev_press), .overflow_o(overflow), .ovf_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) evq.push_back({ev_key, ev_press});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input int n, input int bound);
    int i;
    i = 0;
    while (evq.size() < n && i < bound) begin
      tick(1);
      i++;
    end
  endtask

  task automatic wait_col_change(output int cyc);
    logic [3:0] p;
    p = col_n;
    cyc = 0;
    while (col_n == p && cyc < 100) begin
      tick(1);
      cyc++;
    end
  endtask

  initial begin
    logic [3:0] walk [5];
    int cyc;
    int i;
    walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011;
    walk[3] = 4'b0111; walk[4] = 4'b1110;

    // 1: reset state and column walk
    rst = 1'b1;
    tick(3);
    chk("rst_col_n", col_n, 4'b1111);
    chk("rst_keys", keys, 16'h0000);
    chk("rst_ev_valid", ev_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_col_change(cyc);
      chk($sformatf("walk_col_n_%0d", k), col_n, walk[k]);
      if (k >= 2) chk($sformatf("walk_period_%0d", k), cyc, 22);
    end

    // 2: single key press and release
    evq.delete();
    pressed = 16'h0020;
    wait_ev(1, 6 * SCAN);
    chk("t2_press_count", evq.size(), 1);
    if (evq.size() > 0) chk("t2_press_ev", evq[0], {4'd5, 1'b1});
    chk("t2_keys_pressed", keys, 16'h0020);
    tick(2 * SCAN);
    chk("t2_single_event", evq.size(), 1);
    evq.delete();
    pressed = 16'h0000;
    wait_ev(1, 6 * SCAN);
    chk("t2_release_count", evq.size(), 1);
    if (evq.size() > 0) chk("t2_release_ev", evq[0], {4'd5, 1'b0});
    chk("t2_keys_released", keys, 16'h0000);

    // 3: short glitch on key 10
    evq.delete();
    pressed = 16'h0400;
    tick(150);
    pressed = 16'h0000;
    tick(4 * SCAN);
    chk("t3_keys", keys, 16'h0000);
    chk("t3_no_event", evq.size(), 0);

    // 4: whole column 0 at once
    evq.delete();
    pressed = 16'h1111;
    wait_ev(4, 6 * SCAN);
    chk("t4_count", evq.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < evq.size()) chk($sformatf("t4_ev_%0d", k), evq[k], {4'(4 * k), 1'b1});
    chk("t4_keys", keys, 16'h1111);
    evq.delete();
    pressed = 16'h0000;
    wait_ev(4, 6 * SCAN);
    chk("t4_release_count", evq.size(), 4);
    chk("t4_keys_released", keys, 16'h0000);

    // 5: FIFO full, overflow and clear
    evq.delete();
    ev_ready = 1'b0;
    i = 0;
    while (col_n != 4'b1110 && i < SCAN) begin tick(1); i++; end
    pressed = 16'h006E;
    i = 0;
    while (!overflow && i < 6 * SCAN) begin tick(1); i++; end
    chk("t5_overflow", overflow, 1'b1);
    chk("t5_keys", keys, 16'h006E);
    chk("t5_head_valid", ev_valid, 1'b1);
    chk("t5_head_key", ev_key, 4'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_cleared", overflow, 1'b0);
    ev_ready = 1'b1;
    wait_ev(4, 20);
    tick(10);
    chk("t5_drained", evq.size(), 4);
    walk[0] = 4'd1; walk[1] = 4'd5; walk[2] = 4'd2; walk[3] = 4'd6;
    for (int k = 0; k < 4; k++)
      if (k < evq.size()) chk($sformatf("t5_ev_%0d", k), evq[k], {walk[k], 1'b1});
    chk("t5_empty", ev_valid, 1'b0);
    evq.delete();
    pressed = 16'h0000;
    wait_ev(5, 6 * SCAN);
    chk("t5_release_count", evq.size(), 5);
    chk("t5_keys_released", keys, 16'h0000);

    // 6: reset during UPDATE with key 5 held
    evq.delete();
    pressed = 16'h0020;
    wait_ev(1, 6 * SCAN);
    chk("t6_pre_keys", keys, 16'h0020);
    wait_col_change(cyc);
    tick(18);
    rst = 1'b1;
    tick(2);
    chk("t6_rst_col_n", col_n, 4'b1111);
    chk("t6_rst_keys", keys, 16'h0000);
    chk("t6_rst_ev_valid", ev_valid, 1'b0);
    evq.delete();
    rst = 1'b0;
    tick(1);
    chk("t6_first_col", col_n, 4'b1110);
    tick(150);
    chk("t6_keys_debouncing", keys, 16'h0000);
    wait_ev(1, 6 * SCAN);
    chk("t6_rereport_count", evq.size(), 1);
    if (evq.size() > 0) chk("t6_rereport_ev", evq[0], {4'd5, 1'b1});
    chk("t6_keys", keys, 16'h0020);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
